brl_issue: RTL and testbench

BRL_ISSUE -- requirements
Module: brl_issue

---
 rtl/brl_pkg.sv | 20 ++
 rtl/brl_cmd_fifo.sv | 66 ++++++
 rtl/brl_issue.sv | 125 ++++++++++++
 tb/tb_brl_issue.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brl_pkg.sv
// Shared types and constants for the barrel-shifter command issue block.
package brl_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CMD_W  = DATA_W + SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

endpackage

// File: rtl/brl_cmd_fifo.sv
// Command FIFO with registered write-ready/empty flags and a wrap bit on each pointer.
// With BRL_ISSUE_LEVEL_EN defined, a registered occupancy output is added.
module brl_cmd_fifo
  import brl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wr_cmd,
  output logic [CMD_W-1:0] rd_cmd,
  output logic             wr_ready,
  output logic             empty
`ifdef BRL_ISSUE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             do_push, do_pop, full_nxt, empty_nxt;

  // A full FIFO refuses pushes even when a pop happens on the same edge.
  always_comb begin
    do_push    = push & wr_ready;
    do_pop     = pop & ~empty;
    wr_ptr_nxt = wr_ptr + PW'(do_push);
    rd_ptr_nxt = rd_ptr + PW'(do_pop);
    full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_cmd;
  end

  assign rd_cmd = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_ready <= 1'b0;
      empty    <= 1'b1;
`ifdef BRL_ISSUE_LEVEL_EN
      level    <= '0;
`endif
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ready <= ~full_nxt;
      empty    <= empty_nxt;
`ifdef BRL_ISSUE_LEVEL_EN
      level    <= wr_ptr_nxt - rd_ptr_nxt;
`endif
    end
  end

endmodule

// File: rtl/brl_issue.sv
// Issues queued rotate commands to an external LAT-cycle barrel shifter and hands back results.
// With BRL_ISSUE_LEVEL_EN defined, the cmd_level occupancy output is added.
module brl_issue
  import brl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic [DATA_W-1:0] brl_data_in,
  output logic [SEL_W-1:0]  brl_sel,
  output logic              brl_load,
  input  logic [DATA_W-1:0] brl_data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [SEL_W-1:0]  res_sel
`ifdef BRL_ISSUE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] cmd_level
`endif
);

  localparam int unsigned CNT_W = 2;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [CMD_W-1:0]  fifo_wr, fifo_rd;
  logic              fifo_empty, fifo_pop;
  cmd_t              head;
  logic              load_nxt, res_valid_nxt;
  logic [DATA_W-1:0] data_in_nxt, res_data_nxt;
  logic [SEL_W-1:0]  sel_nxt, res_sel_nxt;

  assign fifo_wr = {cmd_data, cmd_sel};
  assign head    = cmd_t'(fifo_rd);

  brl_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd_valid),
    .pop      (fifo_pop),
    .wr_cmd   (fifo_wr),
    .rd_cmd   (fifo_rd),
    .wr_ready (cmd_ready),
    .empty    (fifo_empty)
`ifdef BRL_ISSUE_LEVEL_EN
    ,
    .level    (cmd_level)
`endif
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    fifo_pop     = 1'b0;
    data_in_nxt  = brl_data_in;
    sel_nxt      = brl_sel;
    res_data_nxt = res_data;
    res_sel_nxt  = res_sel;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_nxt = ISSUE;
      end
      ISSUE: begin
        fifo_pop    = 1'b1;
        res_sel_nxt = head.sel;
        cnt_nxt     = CNT_W'(LAT - 1);
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_data_nxt = brl_data_out;
          state_nxt    = DONE;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_nxt = fifo_empty ? IDLE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase

    // Shifter inputs are loaded on entry to ISSUE and then held until the next issue.
    load_nxt      = (state_nxt == ISSUE);
    res_valid_nxt = (state_nxt == DONE);
    if (load_nxt) begin
      data_in_nxt = head.data;
      sel_nxt     = head.sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      brl_load    <= 1'b0;
      brl_data_in <= '0;
      brl_sel     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_sel     <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      brl_load    <= load_nxt;
      brl_data_in <= data_in_nxt;
      brl_sel     <= sel_nxt;
      res_valid   <= res_valid_nxt;
      res_data    <= res_data_nxt;
      res_sel     <= res_sel_nxt;
    end
  end

endmodule

// File: tb/tb_brl_issue.sv
// Scoreboard bench for brl_issue: one LAT=1 and one LAT=3 instance, each with a shifter model.
module tb_brl_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    int         push_cyc;
    int         exp_lat;
    int         exp_gap;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Instance A: LAT=1
  logic       reset_a, cmd_valid_a, cmd_ready_a, brl_load_a, res_valid_a, res_ready_a;
  logic [7:0] cmd_data_a, brl_data_in_a, brl_data_out_a, res_data_a;
  logic [2:0] cmd_sel_a, brl_sel_a, res_sel_a;
  // Instance B: LAT=3
  logic       reset_b, cmd_valid_b, cmd_ready_b, brl_load_b, res_valid_b, res_ready_b;
  logic [7:0] cmd_data_b, brl_data_in_b, brl_data_out_b, res_data_b;
  logic [2:0] cmd_sel_b, brl_sel_b, res_sel_b;
`ifdef BRL_ISSUE_LEVEL_EN
  logic [2:0] cmd_level_a, cmd_level_b;
`endif

  brl_issue #(.DEPTH(4), .LAT(1)) u_a (
    .clk(clk), .reset(reset_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_data(cmd_data_a), .cmd_sel(cmd_sel_a), .brl_data_in(brl_data_in_a),
    .brl_sel(brl_sel_a), .brl_load(brl_load_a), .brl_data_out(brl_data_out_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a), .res_data(res_data_a),
    .res_sel(res_sel_a)
`ifdef BRL_ISSUE_LEVEL_EN
    , .cmd_level(cmd_level_a)
`endif
  );

  brl_issue #(.DEPTH(4), .LAT(3)) u_b (
    .clk(clk), .reset(reset_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_data(cmd_data_b), .cmd_sel(cmd_sel_b), .brl_data_in(brl_data_in_b),
    .brl_sel(brl_sel_b), .brl_load(brl_load_b), .brl_data_out(brl_data_out_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b),
    .res_sel(res_sel_b)
`ifdef BRL_ISSUE_LEVEL_EN
    , .cmd_level(cmd_level_b)
`endif
  );

  // Shifter environment: arithmetic rotate, flagged by the load; garbage when not exactly LAT after load.
  function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s);
    int v;
    int k;
    v = int'(d);
    k = int'(s);
    return 8'(((v >> k) | (v << (8 - k))) & 255);
  endfunction

  // Reference rotate for expectations: result bit i comes from operand bit (i+s) mod 8.
  function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic [2:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[(i + int'(s)) % 8];
    return r;
  endfunction

  logic [8:0] pa;
  logic [8:0] pb [3];
  always @(posedge clk) begin
    pa    <= {brl_load_a, shf(brl_data_in_a, brl_sel_a)};
    pb[0] <= {brl_load_b, shf(brl_data_in_b, brl_sel_b)};
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign brl_data_out_a = pa[8] ? pa[7:0] : ~pa[7:0];
  assign brl_data_out_b = pb[2][8] ? pb[2][7:0] : ~pb[2][7:0];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare every presented result against the queue head, pop on handshake.
  int seen_a = -1, last_a = -1, loads_a = 0;
  int seen_b = -1, last_b = -1, loads_b = 0;

  always begin
    @(negedge clk);
    #1;
    if (brl_load_a) loads_a++;
    if (reset_a) seen_a = -1;
    else if (res_valid_a) begin
      if (q_a.size() == 0) check("a_spurious_res_valid", int'(res_valid_a), 0);
      else begin
        if (seen_a < 0) begin
          seen_a = cyc;
          if (q_a[0].exp_lat >= 0) check("a_latency", cyc - q_a[0].push_cyc, q_a[0].exp_lat);
          if (q_a[0].exp_gap >= 0) check("a_result_gap", cyc - last_a, q_a[0].exp_gap);
          last_a = cyc;
        end
        check("a_res_data", int'(res_data_a), int'(q_a[0].data));
        check("a_res_sel", int'(res_sel_a), int'(q_a[0].sel));
        if (res_ready_a) begin
          void'(q_a.pop_front());
          seen_a = -1;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (brl_load_b) loads_b++;
    if (reset_b) seen_b = -1;
    else if (res_valid_b) begin
      if (q_b.size() == 0) check("b_spurious_res_valid", int'(res_valid_b), 0);
      else begin
        if (seen_b < 0) begin
          seen_b = cyc;
          if (q_b[0].exp_lat >= 0) check("b_latency", cyc - q_b[0].push_cyc, q_b[0].exp_lat);
          if (q_b[0].exp_gap >= 0) check("b_result_gap", cyc - last_b, q_b[0].exp_gap);
          last_b = cyc;
        end
        check("b_res_data", int'(res_data_b), int'(q_b[0].data));
        check("b_res_sel", int'(res_sel_b), int'(q_b[0].sel));
        if (res_ready_b) begin
          void'(q_b.pop_front());
          seen_b = -1;
        end
      end
    end
  end

  // Push tasks: offer at a negedge, wait (bounded) for ready; acceptance happens on the next edge.
  task automatic push_a(input logic [7:0] d, input logic [2:0] s, input logic [7:0] e,
                        input int lat, input int gap);
    int n = 0;
    @(negedge clk);
    cmd_valid_a = 1'b1; cmd_data_a = d; cmd_sel_a = s;
    while (!cmd_ready_a && n < 100) begin @(negedge clk); n++; end
    if (cmd_ready_a) q_a.push_back('{e, s, cyc + 1, lat, gap});
    else check("a_push_timeout", int'(cmd_ready_a), 1);
  endtask

  task automatic push_b(input logic [7:0] d, input logic [2:0] s, input logic [7:0] e,
                        input int lat, input int gap);
    int n = 0;
    @(negedge clk);
    cmd_valid_b = 1'b1; cmd_data_b = d; cmd_sel_b = s;
    while (!cmd_ready_b && n < 100) begin @(negedge clk); n++; end
    if (cmd_ready_b) q_b.push_back('{e, s, cyc + 1, lat, gap});
    else check("b_push_timeout", int'(cmd_ready_b), 1);
  endtask

  task automatic drain_a();
    int n = 0;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    while (q_a.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("a_drain_left", q_a.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic drain_b();
    int n = 0;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    while (q_b.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("b_drain_left", q_b.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

  initial begin
    int acc;
    int base;
    int n;
    bit rdone;
    logic [7:0] d;
    logic [2:0] s;

    reset_a = 1'b1; reset_b = 1'b1;
    cmd_valid_a = 1'b0; cmd_data_a = '0; cmd_sel_a = '0; res_ready_a = 1'b1;
    cmd_valid_b = 1'b0; cmd_data_b = '0; cmd_sel_b = '0; res_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready_a", int'(cmd_ready_a), 0);
    check("rst_res_valid_a", int'(res_valid_a), 0);
    check("rst_brl_load_a", int'(brl_load_a), 0);
    check("rst_brl_data_in_a", int'(brl_data_in_a), 0);
    check("rst_res_data_a", int'(res_data_a), 0);
    check("rst_cmd_ready_b", int'(cmd_ready_b), 0);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready_a", int'(cmd_ready_a), 1);
    check("post_rst_cmd_ready_b", int'(cmd_ready_b), 1);

    // Single command from idle: 0xB4 ror 2.
    push_a(8'hB4, 3'd2, 8'h2D, 3, -1);
    drain_a();

    // Back-to-back with res_ready high: results 3 cycles apart.
    push_a(8'h5A, 3'd0, 8'h5A, 3, -1);
    push_a(8'h81, 3'd7, 8'h03, 5, 3);
    drain_a();

    // Fill with res_ready low: 4 queued plus 1 issued, the sixth is refused.
    res_ready_a = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d = 8'($urandom);
      s = 3'($urandom);
      cmd_valid_a = 1'b1; cmd_data_a = d; cmd_sel_a = s;
      if (cmd_ready_a) begin
        q_a.push_back('{rot_ref(d, s), s, cyc + 1, -1, -1});
        acc++;
      end
    end
    @(negedge clk);
    cmd_valid_a = 1'b0;
    check("fill_accepted", acc, 5);
    repeat (3) @(negedge clk);
    check("fill_cmd_ready_low", int'(cmd_ready_a), 0);
    res_ready_a = 1'b1;
    drain_a();

    // Hold DONE for 10 cycles with a second command waiting: no new issue.
    res_ready_a = 1'b0;
    push_a(8'h3C, 3'd5, rot_ref(8'h3C, 3'd5), 3, -1);
    push_a(8'hC7, 3'd1, rot_ref(8'hC7, 3'd1), -1, -1);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    n = 0;
    while (!res_valid_a && n < 20) begin @(negedge clk); n++; end
    base = loads_a;
    repeat (10) @(negedge clk);
    check("hold_brl_load_pulses", loads_a - base, 0);
    check("hold_res_valid", int'(res_valid_a), 1);
    res_ready_a = 1'b1;
    drain_a();

    // Randomized traffic with random res_ready back-pressure.
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] rd;
          logic [2:0] rs;
          rd = 8'($urandom);
          rs = 3'($urandom);
          push_a(rd, rs, rot_ref(rd, rs), -1, -1);
          if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            cmd_valid_a = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
          end
        end
        @(negedge clk);
        cmd_valid_a = 1'b0;
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(negedge clk);
          res_ready_a = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready_a = 1'b1;
    drain_a();

    // LAT=3: one load pulse, result 5 cycles after the push.
    base = loads_b;
    push_b(8'hF0, 3'd4, 8'h0F, 5, -1);
    drain_b();
    check("lat3_brl_load_pulses", loads_b - base, 1);

    // Reset in WAIT with two commands queued: everything discarded.
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      s = 3'($urandom);
      push_b(d, s, rot_ref(d, s), -1, -1);
    end
    @(negedge clk);
    cmd_valid_b = 1'b0;
    reset_b = 1'b1;
    q_b.delete();
    @(negedge clk);
    check("midrst_cmd_ready", int'(cmd_ready_b), 0);
    check("midrst_res_valid", int'(res_valid_b), 0);
    check("midrst_brl_load", int'(brl_load_b), 0);
    check("midrst_brl_data_in", int'(brl_data_in_b), 0);
    check("midrst_brl_sel", int'(brl_sel_b), 0);
    check("midrst_res_data", int'(res_data_b), 0);
    check("midrst_res_sel", int'(res_sel_b), 0);
`ifdef BRL_ISSUE_LEVEL_EN
    check("midrst_cmd_level", int'(cmd_level_b), 0);
`endif
    reset_b = 1'b0;
    base = loads_b;
    @(negedge clk);
    check("postrst_cmd_ready", int'(cmd_ready_b), 1);
    repeat (12) @(negedge clk);
    check("postrst_brl_load_pulses", loads_b - base, 0);
    check("postrst_res_valid", int'(res_valid_b), 0);
`ifdef BRL_ISSUE_LEVEL_EN
    check("postrst_cmd_level", int'(cmd_level_b), 0);
`endif

    // Instance B still works after the abort.
    push_b(8'h96, 3'd3, rot_ref(8'h96, 3'd3), 5, -1);
    drain_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
